// File: rtl/accum_pkg.sv
// Shared widths and FSM state type for the six-bit accumulator.
package accum_pkg;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/six_bit_adder.sv
// Six-bit ripple-carry adder with carry-in and carry-out.
module six_bit_adder (
  input  logic [5:0] A,
  input  logic [5:0] B,
  input  logic       C0,
  output logic [5:0] S,
  output logic       Cout
);

  logic [6:0] carry;

  always_comb begin
    carry    = '0;
    S        = '0;
    carry[0] = C0;
    for (int i = 0; i < 6; i++) begin
      S[i]         = A[i] ^ B[i] ^ carry[i];
      carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = carry[6];

endmodule

// File: rtl/six_bit_accumulator.sv
// Sums NUM_SAMPLES six-bit beats into one result with a sticky overflow flag,
// using valid/ready handshakes on both the input and the output side.
module six_bit_accumulator
  import accum_pkg::*;
#(
  parameter int NUM_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf
);

  state_t             state, state_next;
  logic [DATA_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
  logic               ovf, ovf_next;
  logic [DATA_W-1:0]  add_sum;
  logic               add_carry;

  six_bit_adder u_adder (
    .A    (acc),
    .B    (in_data),
    .C0   (1'b0),
    .S    (add_sum),
    .Cout (add_carry)
  );

  assign cnt_inc = cnt + 1'b1;

  // Acceptance is implied by the state: in_ready is high in IDLE and ACCUM only.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;
    if (clear) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc_next   = in_data;
            ovf_next   = 1'b0;
            cnt_next   = CNT_W'(1);
            state_next = (NUM_SAMPLES == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_next = add_sum;
            ovf_next = ovf | add_carry;
            cnt_next = cnt_inc;
            if (cnt_inc == CNT_W'(NUM_SAMPLES)) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      ovf   <= ovf_next;
    end
  end

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_six_bit_accumulator.sv
// Directed self-checking bench: one four-sample and one single-sample
// accumulator share clock and reset; each task checks its own scenario.
module tb_six_bit_accumulator;

  logic       clk;
  logic       rst_n;
  logic       clear, in_valid, out_ready;
  logic [5:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [5:0] out_sum;
  logic       s_clear, s_in_valid, s_out_ready;
  logic [5:0] s_in_data;
  logic       s_in_ready, s_out_valid, s_out_ovf;
  logic [5:0] s_out_sum;

  int checks;
  int errors;

  six_bit_accumulator #(.NUM_SAMPLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  six_bit_accumulator #(.NUM_SAMPLES(1)) dut_single (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (s_clear),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_sum   (s_out_sum),
    .out_ovf   (s_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic beat(input logic [5:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic s_beat(input logic [5:0] d);
    s_in_valid = 1'b1;
    s_in_data  = d;
    @(negedge clk);
    s_in_valid = 1'b0;
  endtask

  task automatic take;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    checks++;
    if (out_sum !== 6'd0 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_result: sum=%0d ovf=%b expected 0 0", out_sum, out_ovf);
    end
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_out_sum !== 6'd0 || s_out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_single: rdy=%b vld=%b sum=%0d ovf=%b expected 1 0 0 0",
               s_in_ready, s_out_valid, s_out_sum, s_out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    beat(6'd10);
    beat(6'd20);
    beat(6'd5);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_early: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    beat(6'd3);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_done: out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
    end
    checks++;
    if (out_sum !== 6'd38 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_sum: sum=%0d ovf=%b expected 38 0", out_sum, out_ovf);
    end
    take();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_taken: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_overflow;
    beat(6'd40);
    beat(6'd30);
    beat(6'd0);
    beat(6'd0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 6'd6 || out_ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_set: vld=%b sum=%0d ovf=%b expected 1 6 1", out_valid, out_sum, out_ovf);
    end
    take();
    for (int i = 0; i < 4; i++) beat(6'd1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 6'd4 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_cleared: vld=%b sum=%0d ovf=%b expected 1 4 0", out_valid, out_sum, out_ovf);
    end
    take();
    beat(6'd63);
    beat(6'd1);
    beat(6'd0);
    beat(6'd0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 6'd0 || out_ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_wrap: vld=%b sum=%0d ovf=%b expected 1 0 1", out_valid, out_sum, out_ovf);
    end
    take();
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 4; i++) beat(6'd2);
    in_valid  = 1'b1;
    in_data   = 6'd9;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 6'd8 || out_ovf !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: vld=%b rdy=%b sum=%0d ovf=%b expected 1 0 8 0",
                 i, out_valid, in_ready, out_sum, out_ovf);
      end
    end
    take();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    // A beat wrongly taken during the output handshake would finish this result early.
    for (int i = 0; i < 3; i++) beat(6'd1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_no_accept: out_valid=%b expected 0", out_valid);
    end
    beat(6'd1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 6'd4) begin
      errors++;
      $display("[TB] FAIL bp_next_sum: vld=%b sum=%0d expected 1 4", out_valid, out_sum);
    end
    take();
  endtask

  task automatic test_bubbles;
    beat(6'd1);
    repeat (2) @(negedge clk);
    beat(6'd2);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bubble_wait: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    beat(6'd3);
    beat(6'd4);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 6'd10 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bubble_sum: vld=%b sum=%0d ovf=%b expected 1 10 0", out_valid, out_sum, out_ovf);
    end
    take();
  endtask

  task automatic test_clear;
    beat(6'd7);
    beat(6'd9);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 6'd5;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_accum: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) beat(6'd1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 6'd4 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_restart: vld=%b sum=%0d ovf=%b expected 1 4 0", out_valid, out_sum, out_ovf);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_done: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) beat(6'd5);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 6'd20 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_after_done: vld=%b sum=%0d ovf=%b expected 1 20 0", out_valid, out_sum, out_ovf);
    end
    take();
  endtask

  task automatic test_single;
    s_beat(6'd63);
    checks++;
    if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_out_sum !== 6'd63 || s_out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_63: vld=%b rdy=%b sum=%0d ovf=%b expected 1 0 63 0",
               s_out_valid, s_in_ready, s_out_sum, s_out_ovf);
    end
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_taken: vld=%b rdy=%b expected 0 1", s_out_valid, s_in_ready);
    end
    s_beat(6'd40);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 6'd40) begin
      errors++;
      $display("[TB] FAIL single_40: vld=%b sum=%0d expected 1 40", s_out_valid, s_out_sum);
    end
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset_midway;
    beat(6'd10);
    beat(6'd10);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 6'd0 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_accum: rdy=%b vld=%b sum=%0d ovf=%b expected 1 0 0 0",
               in_ready, out_valid, out_sum, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    beat(6'd1);
    beat(6'd2);
    beat(6'd3);
    beat(6'd4);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 6'd10 || out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_resume: vld=%b sum=%0d ovf=%b expected 1 10 0", out_valid, out_sum, out_ovf);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 6'd0) begin
      errors++;
      $display("[TB] FAIL rst_done: vld=%b rdy=%b sum=%0d expected 0 1 0", out_valid, in_ready, out_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_no_output: out_valid=%b expected 0", out_valid);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    clear       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    s_clear     = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_clear();
    test_single();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
